// File: rtl/reg_mem.sv
// Single-port register-file memory with registered read data and synchronous clear.
// Optional macro REG_MEM_WRITE_FIRST_EN selects write-first read-during-write (default read-first).
module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // Read port is always active; only the same-address write bypass is configurable.
  always_comb begin
    data_out_d = mem_q[addr];
`ifdef REG_MEM_WRITE_FIRST_EN
    if (wen) begin
      data_out_d = data_in;
    end
`else
    data_out_d = mem_q[addr];
`endif
  end

  // Reset clears storage as well as the output and wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      if (wen) begin
        mem_q[addr] <= data_in;
      end
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_reg_mem.sv
// Self-checking bench for reg_mem: directed steps plus randomized traffic against an array model.
module tb_reg_mem;
  localparam int DW    = 8;
  localparam int AB    = 5;
  localparam int DEPTH = 32;
`ifdef REG_MEM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          wen;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [DEPTH];

  always #5 clk = ~clk;

  reg_mem #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .addr    (addr),
    .data_in (data_in),
    .wen     (wen),
    .clk     (clk),
    .data_out(data_out),
    .rst     (rst)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, compare the registered output.
  task automatic cyc(input int a_wide, input logic [DW-1:0] d, input bit w, input bit r,
                     input string tag);
    int a;
    logic [DW-1:0] old;
    logic [DW-1:0] expv;
    a       = a_wide % DEPTH;
    addr    = a_wide[AB-1:0];
    data_in = d;
    wen     = w;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      expv = '0;
    end else begin
      old = model[a];
      if (w) model[a] = d;
      expv = (w && WF) ? d : old;
    end
    check(tag, data_out, expv);
  endtask

  initial begin
    addr = '0; data_in = '0; wen = 1'b0; rst = 1'b1;

    // Reset, then reads of cleared locations
    cyc(0, 8'h00, 1'b0, 1'b1, "reset");
    cyc(0, 8'h00, 1'b0, 1'b0, "rst_rd0");   check("rst_a0", data_out, 8'h00);
    cyc(13, 8'h00, 1'b0, 1'b0, "rst_rd13"); check("rst_a13", data_out, 8'h00);
    cyc(31, 8'h00, 1'b0, 1'b0, "rst_rd31"); check("rst_a31", data_out, 8'h00);

    // Fill with wrapping addresses wider than the port
    for (int i = 10; i <= 41; i++) cyc(i + 2, DW'(i), 1'b1, 1'b0, "fill");
    cyc(12, 8'($urandom), 1'b0, 1'b0, "rb12"); check("fill_a12", data_out, 8'd10);
    cyc(31, 8'($urandom), 1'b0, 1'b0, "rb31"); check("fill_a31", data_out, 8'd29);
    cyc(0,  8'($urandom), 1'b0, 1'b0, "rb0");  check("fill_a0",  data_out, 8'd30);
    cyc(11, 8'($urandom), 1'b0, 1'b0, "rb11"); check("fill_a11", data_out, 8'd41);

    // Hold: no writes with random data, then full readback
    for (int i = 0; i < 32; i++) cyc(int'($urandom_range(0, 255)), 8'($urandom), 1'b0, 1'b0, "hold");
    for (int i = 0; i < DEPTH; i++) cyc(i, 8'($urandom), 1'b0, 1'b0, "hold_rb");
    cyc(12, 8'h00, 1'b0, 1'b0, "hold12"); check("hold_a12", data_out, 8'd10);
    cyc(11, 8'h00, 1'b0, 1'b0, "hold11"); check("hold_a11", data_out, 8'd41);

    // Latency: addr 3 holds 33 (0x21) from the fill
    cyc(3, 8'hA5, 1'b1, 1'b0, "lat_wr"); check("lat_wr_cycle", data_out, WF ? 8'hA5 : 8'h21);
    cyc(3, 8'h00, 1'b0, 1'b0, "lat_rd"); check("lat_rd", data_out, 8'hA5);

    // Read-during-write
    cyc(7, 8'h11, 1'b1, 1'b0, "rdw_pre");
    cyc(7, 8'h22, 1'b1, 1'b0, "rdw_wr"); check("rdw_same", data_out, WF ? 8'h22 : 8'h11);
    cyc(7, 8'h00, 1'b0, 1'b0, "rdw_rd"); check("rdw_after", data_out, 8'h22);

    // Reset priority and mid-operation reset
    cyc(5, 8'h3C, 1'b1, 1'b1, "rstpri");
    cyc(5, 8'h00, 1'b0, 1'b0, "rstpri_rd"); check("rstpri_a5", data_out, 8'h00);
    cyc(9, 8'h7E, 1'b1, 1'b0, "mid_wr");
    cyc(0, 8'h00, 1'b0, 1'b1, "mid_rst");
    cyc(9, 8'h00, 1'b0, 1'b0, "mid_rd"); check("mid_a9", data_out, 8'h00);

    // Random traffic with occasional resets and wide addresses
    for (int i = 0; i < 400; i++) begin
      cyc(int'($urandom_range(0, 1023)), 8'($urandom), bit'($urandom_range(0, 1)),
          ($urandom_range(0, 29) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
